seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the drive side of the serial sequence-detector link.

---
 rtl/seq_pattern_tx.sv | 151 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB-first, with repeats and gaps.
// Optional: define GAP_PRBS_EN to drive PRBS7 noise on xout during GAP cycles.
//
// Ports:
//   clk, rst (async, active-low)
//   pat_in/rep_in/gap_in + start_valid/start_ready : transfer request
//   xout/xout_valid : serial data; busy : SHIFT or GAP; done : end pulse
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             xout,
  output logic             xout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [REP_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             gap_bit;

  assign accept = start_valid & start_ready;
  assign sh_nxt = sh << 1;

`ifdef GAP_PRBS_EN
  logic [6:0] lfsr;
  logic       gap_step;

  // Advance once for every GAP cycle that gets presented on xout.
  assign gap_step =
    ((state == SHIFT) && (bit_cnt == '0) &&
     (rep_left > REP_W'(1)) && (gap_q != '0)) ||
    ((state == GAP) && (gap_cnt != '0));

  assign gap_bit = lfsr[6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 7'h01;
    end else if (gap_step) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end
`else
  assign gap_bit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      sh          <= '0;
      bit_cnt     <= '0;
      rep_left    <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      xout        <= 1'b0;
      xout_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state       <= SHIFT;
            pat_q       <= pat_in;
            sh          <= pat_in;
            bit_cnt     <= BMAX;
            rep_left    <= (rep_in == '0) ? REP_W'(1) : rep_in;
            gap_q       <= gap_in;
            xout        <= pat_in[WIDTH-1];
            xout_valid  <= 1'b1;
            busy        <= 1'b1;
            start_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - BW'(1);
            sh      <= sh_nxt;
            xout    <= sh_nxt[WIDTH-1];
          end else if (rep_left > REP_W'(1)) begin
            rep_left <= rep_left - REP_W'(1);
            if (gap_q == '0) begin
              sh      <= pat_q;
              bit_cnt <= BMAX;
              xout    <= pat_q[WIDTH-1];
            end else begin
              state      <= GAP;
              gap_cnt    <= gap_q - GAP_W'(1);
              xout       <= gap_bit;
              xout_valid <= 1'b0;
            end
          end else begin
            state       <= IDLE;
            xout        <= 1'b0;
            xout_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            start_ready <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            xout    <= gap_bit;
          end else begin
            state      <= SHIFT;
            sh         <= pat_q;
            bit_cnt    <= BMAX;
            xout       <= pat_q[WIDTH-1];
            xout_valid <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          xout        <= 1'b0;
          xout_valid  <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed bench for seq_pattern_tx.
// Queue-based output model plus literal stream/latency checks.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pat_in = '0;
  logic [3:0] rep_in = '0;
  logic [3:0] gap_in = '0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       xout;
  logic       xout_valid;
  logic       busy;
  logic       done;

  seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP_W(4)) dut (
    .clk(clk), .rst(rst),
    .pat_in(pat_in), .rep_in(rep_in), .gap_in(gap_in),
    .start_valid(start_valid), .start_ready(start_ready),
    .xout(xout), .xout_valid(xout_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected outputs per cycle: {valid, xout, busy, done, ready}
  typedef logic [4:0] exp_t;
  localparam exp_t IDLE_E = 5'b00001;
  exp_t q[$];
  exp_t cur = IDLE_E;
  logic [6:0] mlfsr = 7'h01;
  int cyc = 0;
  int acc_lbl = 0;

  task automatic plan(input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] g);
    int reps;
    logic gb;
    reps = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < reps; k++) begin
      if (k > 0) begin
        for (int j = 0; j < int'(g); j++) begin
`ifdef GAP_PRBS_EN
          gb = mlfsr[6];
          mlfsr = {mlfsr[5:0], mlfsr[6] ^ mlfsr[5]};
`else
          gb = 1'b0;
`endif
          q.push_back({1'b0, gb, 1'b1, 1'b0, 1'b0});
        end
      end
      for (int i = 3; i >= 0; i--)
        q.push_back({1'b1, p[i], 1'b1, 1'b0, 1'b0});
    end
    q.push_back(5'b00011);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cur = IDLE_E;
      mlfsr = 7'h01;
    end else begin
      cyc++;
      if (start_valid && cur[0]) begin
        acc_lbl = cyc;
        plan(pat_in, rep_in, gap_in);
      end
      cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
    end
  end

  logic [63:0] stream = '0;
  int nbits = 0;
  logic [15:0] gapbits = '0;
  int ngap = 0;
  logic done_seen = 1'b0;
  int done_lbl = 0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({xout_valid, xout, busy, done, start_ready} === cur) passes++;
      else $display("FAIL cycle %0d outputs: got %b expected %b",
                    cyc + 1, {xout_valid, xout, busy, done, start_ready}, cur);
      if (xout_valid) begin
        stream = {stream[62:0], xout};
        nbits++;
      end
      if (busy && !xout_valid) begin
        gapbits = {gapbits[14:0], xout};
        ngap++;
      end
      if (done) begin
        done_seen = 1'b1;
        done_lbl = cyc + 1;
      end
    end
  end

  task automatic clear_mon();
    stream = '0; nbits = 0; gapbits = '0; ngap = 0;
    done_seen = 1'b0;
  endtask

  task automatic start(input logic [3:0] p, input logic [3:0] r,
                       input logic [3:0] g);
    @(negedge clk);
    pat_in = p; rep_in = r; gap_in = g; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!done_seen && n < maxc) begin
      @(posedge clk);
      n++;
    end
    if (!done_seen) begin
      checks++;
      $display("FAIL done timeout: no done within %0d cycles", maxc);
    end
  endtask

  task automatic run(input string name, input logic [3:0] p,
                     input logic [3:0] r, input logic [3:0] g,
                     input logic [63:0] exp_s, input int exp_n,
                     input int exp_lat);
    clear_mon();
    start(p, r, g);
    wait_done(300);
    chk({name, " bits"}, stream, exp_s);
    chk({name, " nbits"}, nbits, exp_n);
    chk({name, " latency"}, done_lbl - acc_lbl, exp_lat);
  endtask

  logic [63:0] exp15;
  int a0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset start_ready", start_ready, 1);
    chk("reset busy", busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run("rep1", 4'b1011, 4'd1, 4'd0, 64'hB, 4, 5);
    run("rep3", 4'b1011, 4'd3, 4'd0, 64'hBBB, 12, 13);
    run("rep2gap2", 4'b1011, 4'd2, 4'd2, 64'hBB, 8, 11);
    chk("rep2gap2 gap zeros", gapbits[1:0], 0);
    chk("rep2gap2 ngap", ngap, 2);
    run("rep0", 4'b0110, 4'd0, 4'd5, 64'h6, 4, 5);
    exp15 = '0;
    for (int i = 0; i < 15; i++) exp15 = (exp15 << 4) | 64'hB;
    run("rep15", 4'b1011, 4'd15, 4'd0, exp15, 60, 61);

    // Start while busy is ignored; start in done cycle is accepted.
    clear_mon();
    @(negedge clk);
    pat_in = 4'b1011; rep_in = 4'd2; gap_in = 4'd0; start_valid = 1'b1;
    @(negedge clk);
    a0 = acc_lbl;
    pat_in = 4'b0110; rep_in = 4'd1; gap_in = 4'd3;
    chk("busy start_ready", start_ready, 0);
    repeat (2) @(negedge clk);
    chk("busy xout unchanged", xout, 1);
    wait_done(50);
    #1 start_valid = 1'b0;
    chk("first latency", done_lbl - a0, 9);
    chk("b2b accepted", acc_lbl, done_lbl);
    @(negedge clk);
    chk("b2b first bit valid", xout_valid, 1);
    chk("b2b first bit", xout, 0);
    done_seen = 1'b0;
    wait_done(50);
    chk("b2b stream", stream, 64'hBB6);
    chk("b2b latency", done_lbl - acc_lbl, 5);

    // Asynchronous reset mid-transfer.
    clear_mon();
    start(4'b1011, 4'd3, 4'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid rst xout_valid", xout_valid, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst start_ready", start_ready, 1);
    chk("mid rst done", done, 0);
    chk("mid rst xout", xout, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid rst no done", done_seen, 0);

    // First gap after reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
    start(4'b1011, 4'd2, 4'd8);
    wait_done(50);
    chk("gap8 ngap", ngap, 8);
`ifdef GAP_PRBS_EN
    chk("gap8 bits", gapbits[7:0], 8'b00000010);
`else
    chk("gap8 bits", gapbits[7:0], 8'b00000000);
`endif
    chk("gap8 stream", stream, 64'hBB);
    chk("gap8 latency", done_lbl - acc_lbl, 17);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
